// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// load_store_unit_if : request/response and data-RAM bundle of the LSU
// Revision: 1.0
// ============================================================================
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic        mem_request;
    logic        mem_w_en;
    logic [7:0]  mem_address;
    logic [3:0]  mem_masking;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
               mem_request, mem_w_en, mem_address, mem_masking, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
               mem_request, mem_w_en, mem_address, mem_masking, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : RV32I memory-stage access unit for a 256 x 32-bit RAM
// Revision: 1.0
// ============================================================================
module load_store_unit (
    input  logic                    clk,
    input  logic                    rst_n,
    load_store_unit_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RESP      = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        acc_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_fmt;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[31:10];

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.stall      = bus.req_valid & ~bus.req_ready;
    assign accept         = bus.req_valid & bus.req_ready;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = err_q & (state_q == RESP);
    assign bus.resp_rdata = rdata_q;

    always_comb begin
        acc_err = 1'b0;
        case (bus.req_funct3)
            3'd0:    acc_err = 1'b0;
            3'd1:    acc_err = bus.req_addr[0];
            3'd2:    acc_err = (bus.req_addr[1:0] != 2'b00);
            3'd4:    acc_err = bus.req_we;
            3'd5:    acc_err = bus.req_we | bus.req_addr[0];
            default: acc_err = 1'b1;
        endcase
    end

    // RAM port is live only in a legal accept cycle and never during reset
    always_comb begin
        bus.mem_request    = 1'b0;
        bus.mem_w_en       = 1'b0;
        bus.mem_address    = 8'd0;
        bus.mem_masking    = 4'b0000;
        bus.mem_write_data = 32'd0;
        if (accept && !acc_err && rst_n) begin
            bus.mem_request = 1'b1;
            bus.mem_address = bus.req_addr[9:2];
            if (bus.req_we) begin
                bus.mem_w_en = 1'b1;
                case (bus.req_funct3[1:0])
                    2'd0: begin
                        bus.mem_masking    = 4'b0001 << bus.req_addr[1:0];
                        bus.mem_write_data = {4{bus.req_wdata[7:0]}};
                    end
                    2'd1: begin
                        bus.mem_masking    = 4'b0011 << {bus.req_addr[1], 1'b0};
                        bus.mem_write_data = {2{bus.req_wdata[15:0]}};
                    end
                    default: begin
                        bus.mem_masking    = 4'b1111;
                        bus.mem_write_data = bus.req_wdata;
                    end
                endcase
            end
        end
    end

    always_comb begin
        ld_byte = 8'd0;
        case (lo_q)
            2'd0:    ld_byte = bus.mem_read_data[7:0];
            2'd1:    ld_byte = bus.mem_read_data[15:8];
            2'd2:    ld_byte = bus.mem_read_data[23:16];
            default: ld_byte = bus.mem_read_data[31:24];
        endcase
        ld_half = lo_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        case (f3_q)
            3'd0:    load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    load_fmt = {24'd0, ld_byte};
            3'd1:    load_fmt = {{16{ld_half[15]}}, ld_half};
            3'd5:    load_fmt = {16'd0, ld_half};
            default: load_fmt = bus.mem_read_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d = acc_err;
                    if (acc_err || bus.req_we) begin
                        rdata_d = 32'd0;
                        state_d = RESP;
                    end else begin
                        lo_d    = bus.req_addr[1:0];
                        f3_d    = bus.req_funct3;
                        state_d = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                rdata_d = load_fmt;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= 2'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : directed self-checking bench with a behavioural RAM
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:255];

    always @(posedge clk) begin
        if (bus.mem_request) begin
            if (bus.mem_w_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.mem_masking[i])
                        ram[bus.mem_address][i*8 +: 8] <= bus.mem_write_data[i*8 +: 8];
                end
            end else begin
                bus.mem_read_data <= ram[bus.mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("comparison %s did not hold", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        #1;
    endtask

    task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [7:0] exp_addr,
                         input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
        drive(1'b1, f3, addr, wdata);
        check({tag, " mem_request"}, {31'd0, bus.mem_request}, 32'd1);
        check({tag, " mem_w_en"}, {31'd0, bus.mem_w_en}, 32'd1);
        check({tag, " mem_address"}, {24'd0, bus.mem_address}, {24'd0, exp_addr});
        check({tag, " mem_masking"}, {28'd0, bus.mem_masking}, {28'd0, exp_mask});
        check({tag, " mem_write_data"}, bus.mem_write_data, exp_wdata);
        tick();
        idle();
        check({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        check({tag, " resp_err"}, {31'd0, bus.resp_err}, 32'd0);
        check({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
        tick();
        check({tag, " back to idle"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [7:0] exp_addr, input logic [31:0] exp_rdata);
        drive(1'b0, f3, addr, 32'h0);
        check({tag, " mem_request"}, {31'd0, bus.mem_request}, 32'd1);
        check({tag, " mem_w_en"}, {31'd0, bus.mem_w_en}, 32'd0);
        check({tag, " mem_masking"}, {28'd0, bus.mem_masking}, 32'd0);
        check({tag, " mem_address"}, {24'd0, bus.mem_address}, {24'd0, exp_addr});
        tick();
        idle();
        check({tag, " wait resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, " wait req_ready"}, {31'd0, bus.req_ready}, 32'd0);
        tick();
        check({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        check({tag, " resp_err"}, {31'd0, bus.resp_err}, 32'd0);
        check({tag, " resp_rdata"}, bus.resp_rdata, exp_rdata);
        tick();
        check({tag, " resp_valid drop"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, " rdata held"}, bus.resp_rdata, exp_rdata);
    endtask

    task automatic bad(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr);
        drive(we, f3, addr, 32'hFFFF_FFFF);
        check({tag, " mem_request"}, {31'd0, bus.mem_request}, 32'd0);
        tick();
        idle();
        check({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        check({tag, " resp_err"}, {31'd0, bus.resp_err}, 32'd1);
        check({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        drive(1'b1, 3'd2, 32'h10, 32'h1111_1111);
        #2;
        check("reset mem_request", {31'd0, bus.mem_request}, 32'd0);
        check("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("reset resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("reset resp_rdata", bus.resp_rdata, 32'd0);
        tick();
        check("reset hold mem_request", {31'd0, bus.mem_request}, 32'd0);
        idle();
        #2 rst_n = 1'b1;
        tick();

        store("SW", 3'd2, 32'h10, 32'hDEAD_BEEF, 8'h04, 4'b1111, 32'hDEAD_BEEF);
        store("SH", 3'd1, 32'h12, 32'hFFFF_1234, 8'h04, 4'b1100, 32'h1234_1234);
        store("SB", 3'd0, 32'h13, 32'h0000_00A5, 8'h04, 4'b1000, 32'hA5A5_A5A5);
        load("LW merged", 3'd2, 32'h10, 8'h04, 32'hA534_BEEF);
        store("SW2", 3'd2, 32'h10, 32'h80FF_7F01, 8'h04, 4'b1111, 32'h80FF_7F01);
        load("LB", 3'd0, 32'h13, 8'h04, 32'hFFFF_FF80);
        load("LBU", 3'd4, 32'h13, 8'h04, 32'h0000_0080);
        load("LB lane0", 3'd0, 32'h10, 8'h04, 32'h0000_0001);
        load("LH", 3'd1, 32'h12, 8'h04, 32'hFFFF_80FF);
        load("LHU", 3'd5, 32'h10, 8'h04, 32'h0000_7F01);
        load("LW high bits", 3'd2, 32'hFFFF_FC10, 8'h04, 32'h80FF_7F01);

        bad("LW misaligned", 1'b0, 3'd2, 32'h06);
        bad("LH odd", 1'b0, 3'd1, 32'h11);
        bad("LHU odd", 1'b0, 3'd5, 32'h13);
        bad("SBU illegal", 1'b1, 3'd4, 32'h10);
        bad("funct3 3", 1'b0, 3'd3, 32'h10);

        // back-to-back loads with req_valid held throughout
        drive(1'b0, 3'd2, 32'h10, 32'h0);
        check("b2b first accept", {31'd0, bus.mem_request}, 32'd1);
        check("b2b first stall", {31'd0, bus.stall}, 32'd0);
        tick();
        check("b2b stall wait", {31'd0, bus.stall}, 32'd1);
        check("b2b no request wait", {31'd0, bus.mem_request}, 32'd0);
        tick();
        check("b2b stall resp", {31'd0, bus.stall}, 32'd1);
        check("b2b resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("b2b rdata", bus.resp_rdata, 32'h80FF_7F01);
        tick();
        check("b2b second accept", {31'd0, bus.mem_request}, 32'd1);
        check("b2b second stall", {31'd0, bus.stall}, 32'd0);
        tick();
        check("b2b second wait", {31'd0, bus.req_ready}, 32'd0);

        // reset in the middle of the second load's wait cycle
        rst_n = 1'b0;
        #1;
        check("mid reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("mid reset mem_request", {31'd0, bus.mem_request}, 32'd0);
        check("mid reset rdata", bus.resp_rdata, 32'd0);
        idle();
        @(posedge clk);
        #4 rst_n = 1'b1;
        tick();
        check("post reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("post reset req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        check("post reset still quiet", {31'd0, bus.resp_valid}, 32'd0);

        load("LW after reset", 3'd2, 32'h10, 8'h04, 32'h80FF_7F01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; the data-memory word address is fixed at 8 bits, 256 x 32-bit words.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  in  1  memory-stage access request.
REQ-005 SHALL have port req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  in  3  RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  out  32  formatted load data; 0 for stores and errors.
REQ-012 SHALL have port resp_err  out  1  qualifies resp_valid; misaligned or illegal access.
REQ-013 SHALL have port stall  out  1  equals req_valid & ~req_ready; pipeline hold.
REQ-014 SHALL have ports mem_request (out 1), mem_w_en (out 1), mem_address (out 8), mem_masking (out 4) and mem_write_data (out 32), all driving the RAM.
REQ-015 SHALL have port mem_read_data  in  32  RAM word, valid the cycle after a read is sampled.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_WAIT and RESP; LOAD_WAIT and RESP each last exactly one cycle.
REQ-017 SHALL drive the mem_* outputs combinationally only in an IDLE accept cycle; mem_request = 0 in every other cycle.
REQ-018 SHALL set mem_address = req_addr[9:2] and ignore req_addr[31:10].
REQ-019 SHALL flag an error for: H/HU with addr[0] = 1; W with addr[1:0] != 0; stores with funct3 in {4,5}; funct3 in {3,6,7}.
REQ-020 SHALL, on an error, assert no mem_request and go IDLE -> RESP with resp_err = 1 and resp_rdata = 0.
REQ-021 SHALL, on a store, drive mem_w_en = 1 and mem_masking = 0001<<addr[1:0] (B), 0011<<{addr[1],0} (H) or 1111 (W).
REQ-022 SHALL replicate store data across lanes: byte x4 for B, halfword x2 for H, unchanged for W.
REQ-023 SHALL take a store IDLE -> RESP; resp_valid is high in the cycle after accept, with resp_rdata = 0.
REQ-024 SHALL, on a load, drive mem_w_en = 0 and mem_masking = 0000, then go IDLE -> LOAD_WAIT -> RESP.
REQ-025 SHALL register addr[1:0] and funct3 at load accept for later data formatting.
REQ-026 SHALL, in LOAD_WAIT, select a lane from mem_read_data, extend it and register the result into resp_rdata.
REQ-027 SHALL extend loads as: B sign-extends byte[addr[1:0]]; BU zero-extends it; H/HU sign/zero-extend halfword[addr[1]]; W passes the full word.
REQ-028 SHALL raise resp_valid in RESP only, i.e. 2 cycles after load accept and 1 after store or error accept.
REQ-029 SHALL hold resp_rdata until the next response is produced.
REQ-030 SHALL return RESP -> IDLE unconditionally; a new request is accepted in the cycle after resp_valid.
REQ-031 SHALL ignore req_* while req_ready = 0; the requester holds them stable under stall.

Reset
REQ-032 SHALL, while rst_n = 0, force state = IDLE and resp_valid, resp_err, resp_rdata and the registered fields to 0.
REQ-033 SHALL, while rst_n = 0, force mem_request = 0 combinationally.
REQ-034 SHALL, on reset mid-LOAD_WAIT, abandon the load: no resp_valid is produced and the first post-reset cycle is IDLE.

Verification
REQ-035 SHALL pass: SW addr 0x10, data 0xDEADBEEF -> mem_address 0x04, mask 1111; resp_valid next cycle, resp_err 0.
REQ-036 SHALL pass: SB addr 0x13, data 0x000000A5 -> mask 1000, mem_write_data 0xA5A5A5A5.
REQ-037 SHALL pass: LB addr 0x13 with RAM word 0x80FF7F01 -> resp_rdata 0xFFFFFF80 two cycles after accept; LBU -> 0x00000080.
REQ-038 SHALL pass: LH addr 0x12 with word 0x80FF7F01 -> 0xFFFF80FF; LHU addr 0x10 -> 0x00007F01.
REQ-039 SHALL pass: LW addr 0x06 -> no mem_request, resp_valid + resp_err next cycle, resp_rdata 0.
REQ-040 SHALL pass: back-to-back LW with req_valid held -> stall high in LOAD_WAIT and RESP, second accept in cycle 3; rst_n low in LOAD_WAIT -> no resp_valid.
